// File: rtl/as_test_monitor.sv
// Self-check monitor: per-channel verdict FSMs fed by chip-select status writes,
// aggregated into done/pass/fail with first-failure capture. Watchdog: AS_TESTMON_TIMEOUT_EN.
module as_testmon_ch #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned PROGRESS_CODE  = 4,
  parameter int unsigned PASS_CODE      = 1,
  parameter int unsigned MIN_PROGRESS   = 1,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [2:0]        state_o,
  output logic [2:0]        state_d_o,
  output logic [CNT_W-1:0]  prog_o,
  output logic [DATA_W-1:0] fcode_o
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RUN = 3'd1, S_PASS = 3'd2, S_FAIL = 3'd3, S_TMO = 3'd4
  } st_e;

  localparam logic [DATA_W-1:0] PROG_C = DATA_W'(PROGRESS_CODE);
  localparam logic [DATA_W-1:0] PASS_C = DATA_W'(PASS_CODE);
  localparam logic [CNT_W-1:0]  MIN_C  = CNT_W'(MIN_PROGRESS);

  st_e              state_q, state_d;
  logic [CNT_W-1:0] prog_q, prog_d;
  logic             acc;

  assign acc = wr_i && (state_q == S_RUN);

`ifdef AS_TESTMON_TIMEOUT_EN
  localparam int unsigned    WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_exp;

  assign wd_exp = (state_q == S_RUN) && (wd_q == WD_LIM);

  // An accepted write in the expiry cycle reloads the count instead of timing out.
  always_comb begin
    wd_d = wd_q;
    if (start_i || acc)                     wd_d = '0;
    else if (state_q == S_RUN && !wd_exp)   wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    fcode_o = '0;
    if (start_i) begin
      state_d = S_RUN;
      prog_d  = '0;
    end else if (acc) begin
      if (data_i == PROG_C) begin
        if (prog_q != '1) prog_d = prog_q + 1'b1;
      end else if (data_i == PASS_C && prog_q >= MIN_C) begin
        state_d = S_PASS;
      end else begin
        state_d = S_FAIL;
        fcode_o = data_i;
      end
    end
`ifdef AS_TESTMON_TIMEOUT_EN
    else if (wd_exp) begin
      state_d = S_TMO;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      prog_q  <= '0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
    end
  end

  assign state_o   = state_q;
  assign state_d_o = state_d;
  assign prog_o    = prog_q;
endmodule

module as_test_monitor #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned NR_CH          = 4,
  parameter int unsigned PROGRESS_CODE  = 4,
  parameter int unsigned PASS_CODE      = 1,
  parameter int unsigned MIN_PROGRESS   = 1,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CH_W          = (NR_CH > 1) ? $clog2(NR_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic                    cs_i,
  input  logic [CH_W-1:0]         ch_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic [3*NR_CH-1:0]      status_o,
  output logic [CNT_W*NR_CH-1:0]  progress_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic [CH_W-1:0]         fail_ch_o,
  output logic [DATA_W-1:0]       fail_code_o
);
  localparam logic [2:0] ST_PASS = 3'd2;
  localparam logic [2:0] ST_FAIL = 3'd3;
  localparam logic [2:0] ST_TMO  = 3'd4;

  logic [NR_CH-1:0][2:0]        st_q, st_d;
  logic [NR_CH-1:0][CNT_W-1:0]  prog;
  logic [NR_CH-1:0][DATA_W-1:0] fcode;
  logic [NR_CH-1:0]             wr;

  logic              done_q, done_d, pass_q, pass_d, fail_q, fail_d, hit;
  logic [CH_W-1:0]   fail_ch_q, fail_ch_d;
  logic [DATA_W-1:0] fail_code_q, fail_code_d;

  // Channel selects outside 0..NR_CH-1 match no lane and are dropped.
  for (genvar i = 0; i < NR_CH; i++) begin : g_ch
    assign wr[i] = cs_i && !start_i && (ch_i == CH_W'(i));
    as_testmon_ch #(
      .DATA_W(DATA_W), .PROGRESS_CODE(PROGRESS_CODE), .PASS_CODE(PASS_CODE),
      .MIN_PROGRESS(MIN_PROGRESS), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .wr_i(wr[i]), .data_i(data_i),
      .state_o(st_q[i]), .state_d_o(st_d[i]), .prog_o(prog[i]), .fcode_o(fcode[i])
    );
  end

  // Flags come from next-state so they land on the same edge as status_o.
  // With no failure held, any failing next-state is new; lowest index wins.
  always_comb begin
    done_d      = 1'b1;
    pass_d      = 1'b1;
    fail_d      = 1'b0;
    hit         = 1'b0;
    fail_ch_d   = fail_ch_q;
    fail_code_d = fail_code_q;
    for (int i = 0; i < NR_CH; i++) begin
      if (st_d[i] != ST_PASS && st_d[i] != ST_FAIL && st_d[i] != ST_TMO) done_d = 1'b0;
      if (st_d[i] != ST_PASS) pass_d = 1'b0;
      if (st_d[i] == ST_FAIL || st_d[i] == ST_TMO) begin
        fail_d = 1'b1;
        if (!fail_q && !hit) begin
          hit         = 1'b1;
          fail_ch_d   = CH_W'(i);
          fail_code_d = fcode[i];
        end
      end
    end
    if (start_i) begin
      fail_ch_d   = '0;
      fail_code_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_ch_q   <= '0;
      fail_code_q <= '0;
    end else begin
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_ch_q   <= fail_ch_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign status_o    = st_q;
  assign progress_o  = prog;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign fail_ch_o   = fail_ch_q;
  assign fail_code_o = fail_code_q;
endmodule

// File: tb/tb_as_test_monitor.sv
// Bench for as_test_monitor: directed plan steps plus random writes against a
// cycle-count reference model (TIMEOUT_CYCLES=16 when the watchdog is built in).
module tb_as_test_monitor;
  localparam int TMO = 16;
`ifdef AS_TESTMON_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0, rstn_i = 1'b0, start_i = 1'b0, cs_i = 1'b0;
  logic [1:0]  ch_i = '0;
  logic [7:0]  data_i = '0;
  logic [11:0] status_o;
  logic [31:0] progress_o;
  logic        done_o, pass_o, fail_o;
  logic [1:0]  fail_ch_o;
  logic [7:0]  fail_code_o;

  as_test_monitor #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .cs_i(cs_i), .ch_i(ch_i),
    .data_i(data_i), .status_o(status_o), .progress_o(progress_o), .done_o(done_o),
    .pass_o(pass_o), .fail_o(fail_o), .fail_ch_o(fail_ch_o), .fail_code_o(fail_code_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0, checks = 0;
  int m_st[4], m_prog[4], m_last[4];
  int cyc = 0, m_fch = 0, m_fcode = 0;
  bit m_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_prog[i] = 0; m_last[i] = 0; end
    m_fail = 0; m_fch = 0; m_fcode = 0;
  endtask

  // One clock edge of the behavioural reference: 0 IDLE 1 RUN 2 PASS 3 FAIL 4 TIMEOUT.
  task automatic mstep(input bit s, input bit c, input int ch, input int d);
    int code[4];
    cyc++;
    if (s) begin
      for (int i = 0; i < 4; i++) begin m_st[i] = 1; m_prog[i] = 0; m_last[i] = cyc; end
      m_fail = 0; m_fch = 0; m_fcode = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        code[i] = 0;
        if (m_st[i] == 1) begin
          if (c && ch == i) begin
            m_last[i] = cyc;
            if (d == 4) m_prog[i] = (m_prog[i] < 255) ? m_prog[i] + 1 : 255;
            else if (d == 1 && m_prog[i] >= 1) m_st[i] = 2;
            else begin m_st[i] = 3; code[i] = d; end
          end else if (TMO_EN && cyc - m_last[i] >= TMO) begin
            m_st[i] = 4;
          end
        end
      end
      if (!m_fail)
        for (int i = 3; i >= 0; i--)
          if (m_st[i] >= 3) begin m_fail = 1; m_fch = i; m_fcode = code[i]; end
    end
  endtask

  task automatic checkall(input string tag);
    logic [11:0] es;
    logic [31:0] ep;
    bit ed, epa;
    ed = 1; epa = 1;
    for (int i = 0; i < 4; i++) begin
      es[3*i +: 3] = 3'(m_st[i]);
      ep[8*i +: 8] = 8'(m_prog[i]);
      if (m_st[i] < 2) ed = 0;
      if (m_st[i] != 2) epa = 0;
    end
    chk({tag, ".status"},    32'(status_o),    32'(es));
    chk({tag, ".progress"},  progress_o,       ep);
    chk({tag, ".done"},      32'(done_o),      32'(ed));
    chk({tag, ".pass"},      32'(pass_o),      32'(epa));
    chk({tag, ".fail"},      32'(fail_o),      32'(m_fail));
    chk({tag, ".fail_ch"},   32'(fail_ch_o),   32'(m_fch));
    chk({tag, ".fail_code"}, 32'(fail_code_o), 32'(m_fcode));
  endtask

  task automatic drive(input string tag, input bit s, input bit c, input int ch, input int d);
    start_i = s; cs_i = c; ch_i = 2'(ch); data_i = 8'(d);
    @(posedge clk_i);
    mstep(s, c, ch % 4, d);
    #1;
    checkall(tag);
  endtask

  initial begin
    mreset();
    #12;
    checkall("reset");
    rstn_i = 1'b1;

    // all channels pass
    drive("t1", 1, 0, 0, 0);
    drive("t1", 0, 1, 0, 4); drive("t1", 0, 1, 0, 4); drive("t1", 0, 1, 0, 1);
    for (int c = 1; c < 4; c++) begin drive("t1", 0, 1, c, 4); drive("t1", 0, 1, c, 1); end
    chk("t1_status", 32'(status_o), 32'h492);
    chk("t1_prog0", 32'(progress_o[7:0]), 32'd2);
    chk("t1_done_pass", {30'd0, done_o, pass_o}, 32'd3);

    // PASS without progress fails; later failure does not overwrite the capture
    drive("t2", 1, 0, 0, 0);
    drive("t2", 0, 1, 2, 1);
    chk("t2_ch2", 32'(status_o[8:6]), 32'd3);
    drive("t2", 0, 1, 0, 8'h55);
    chk("t2_cap", {fail_ch_o, fail_code_o}, {22'd0, 2'd2, 8'd1});

    // writes to a failed channel are ignored (ch 5 aliases to 1 on a 2-bit bus)
    drive("t3", 1, 0, 0, 0);
    drive("t3", 0, 1, 1, 8'h7F);
    drive("t3", 0, 1, 1, 4); drive("t3", 0, 1, 1, 1); drive("t3", 0, 1, 5, 4);
    chk("t3_status", 32'(status_o), 32'h259);
    chk("t3_code", 32'(fail_code_o), 32'h7F);

    // watchdog: silent ch0 times out 16 edges after start
    drive("t4", 1, 0, 0, 0);
    for (int k = 0; k < 15; k++) drive("t4", 0, 0, 0, 0);
    chk("t4_pre", 32'(status_o[2:0]), 32'd1);
    drive("t4", 0, 0, 0, 0);
    chk("t4_tmo", 32'(status_o[2:0]), TMO_EN ? 32'd4 : 32'd1);
    chk("t4_code", 32'(fail_code_o), 32'd0);
    drive("t4b", 1, 0, 0, 0);
    for (int k = 0; k < 15; k++) drive("t4b", 0, 0, 0, 0);
    drive("t4b", 0, 1, 0, 4);
    chk("t4b_run", 32'(status_o[2:0]), 32'd1);

    // progress saturation then pass
    drive("t5", 1, 0, 0, 0);
    for (int k = 0; k < 300; k++) drive("t5", 0, 1, 3, 4);
    chk("t5_sat", 32'(progress_o[31:24]), 32'd255);
    drive("t5", 0, 1, 3, 1);
    chk("t5_pass", 32'(status_o[11:9]), 32'd2);

    // asynchronous reset mid-test, then start beats a same-cycle write
    drive("t6", 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive("t6", 0, 1, 0, 4);
    chk("t6_prog3", 32'(progress_o[7:0]), 32'd3);
    #2 rstn_i = 1'b0;
    #1 mreset();
    checkall("t6_async");
    start_i = 0; cs_i = 0;
    @(posedge clk_i); #1 checkall("t6_held");
    @(negedge clk_i) rstn_i = 1'b1;
    drive("t6_start", 1, 1, 0, 4);
    chk("t6_run", 32'(status_o), 32'h249);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      int r, d;
      r = $urandom_range(99);
      d = (r < 60) ? 4 : (r < 80) ? 1 : $urandom_range(255);
      drive("rnd", $urandom_range(39) == 0, $urandom_range(9) < 7, $urandom_range(3), d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/as_test_monitor.md
# as_test_monitor

Synthesizable self-check monitor for integration tests. It watches chip-select-qualified status writes from one or more test programs on the RISC-V core and tracks a per-channel verdict: progress markers, pass, fail, or watchdog timeout. It aggregates these into global done/pass/fail flags and captures the first failure. It sits beside the GPIO block on the memory-mapped write path, so pass/fail can be read from silicon or FPGA without a simulator.

## Interface
Parameters:
- DATA_W, 8, width of the status code bus
- NR_CH, 4, number of independent test channels (≥1)
- PROGRESS_CODE, 4, code counted as a progress marker
- PASS_CODE, 1, code that ends a channel as passed
- MIN_PROGRESS, 1, progress markers required before PASS_CODE is accepted as a pass
- CNT_W, 8, width of per-channel progress counter (saturating)
- TIMEOUT_CYCLES, 1024, watchdog limit in clk_i cycles (only with AS_TESTMON_TIMEOUT_EN)

Ports:
- clk_i  in  1  system clock, all logic rising-edge
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse: arm all channels (IDLE→RUN, counters cleared)
- cs_i  in  1  status write strobe
- ch_i  in  $clog2(NR_CH) (min 1)  target channel of the write
- data_i  in  DATA_W  status code
- status_o  out  3*NR_CH  per-channel state: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT
- progress_o  out  CNT_W*NR_CH  per-channel progress count
- done_o  out  1  all channels in PASS/FAIL/TIMEOUT
- pass_o  out  1  done_o and all channels PASS
- fail_o  out  1  any channel FAIL or TIMEOUT (sticky)
- fail_ch_o  out  $clog2(NR_CH)  channel of first failure
- fail_code_o  out  DATA_W  code of first failure; 0 for timeout

## Operation
- Per-channel FSM: IDLE → RUN on start_i. In RUN, an accepted write (cs_i=1, ch_i<NR_CH, channel in RUN):
  - data_i==PROGRESS_CODE: progress +1, saturates at 2^CNT_W−1, stay RUN.
  - data_i==PASS_CODE and progress≥MIN_PROGRESS: → PASS.
  - data_i==PASS_CODE and progress<MIN_PROGRESS: → FAIL, code=PASS_CODE.
  - any other value: → FAIL, code=data_i.
- Writes to IDLE or terminal channels, or with ch_i≥NR_CH, are ignored with no state change.
- start_i in any state re-arms every channel to RUN and clears progress, watchdogs, and the first-failure capture. fail_o stays asserted only until this re-arm.
- start_i and cs_i in the same cycle: start_i wins; the write is dropped.
- First-failure capture: latched only while no failure is held. If channels fail in the same cycle, the lowest index wins.

## Timing
- All outputs are registered. Reset values: status_o all IDLE, progress_o 0, done_o/pass_o/fail_o 0, fail_ch_o 0, fail_code_o 0.
- A write sampled at edge N is visible on status_o/progress_o after edge N. done_o, pass_o, and fail_o are visible the same cycle, because they are computed from next-state.
- Watchdog (when enabled):
  - Each RUN channel counts cycles since arming or since its last accepted write.
  - If the count reaches TIMEOUT_CYCLES−1 with no accepted write that cycle, the channel goes to TIMEOUT at the next edge.
  - An accepted write in the expiry cycle wins; the count reloads to 0.
- rstn_i assertion mid-test forces reset values immediately (asynchronously). Release is clean on the next clk_i edge.

## Configuration
- AS_TESTMON_TIMEOUT_EN defined: per-channel watchdog counters and the TIMEOUT state are present.
- Not defined: no counters are synthesized, TIMEOUT is never reported, and TIMEOUT_CYCLES is ignored. A hung channel stays in RUN, so done_o stays 0.

## Test plan
- Reset, start_i, then ch0 writes 4,4,1 and ch1–3 each write 4,1 → all status 2, progress_o ch0=2, done_o=1, pass_o=1, fail_o=0.
- start_i, then ch2 writes 1 with no prior 4 (MIN_PROGRESS=1) → ch2 status 3, fail_o=1, fail_ch_o=2, fail_code_o=1; later ch0 writes 0x55 → capture unchanged.
- start_i, then ch1 writes 0x7F; writes to ch1 afterward and a write with ch_i=5 (NR_CH=4) → ch1 FAIL with code 0x7F, no other state changes.
- With macro, TIMEOUT_CYCLES=16: start_i, ch0 silent → ch0 status 4 exactly 16 cycles after start_i, fail_code_o=0. A write of 4 in cycle 15 keeps RUN. Without macro: ch0 stays 1.
- 300 writes of 4 to ch3 (CNT_W=8) → progress 255 (saturated), then 1 → PASS.
- rstn_i low while ch0 is in RUN with progress 3 → all outputs at reset values. start_i with cs_i=1/data 4 in the same cycle → RUN, progress 0.
